dest_reg_pipeline: RTL and testbench

Producer side of the forwarding/hazard interface. Carries each issued instruction's destination-register information from ID through the EX, MEM and WB stages. Drives the RD_EX/RD_MEM/RD_WB, EX_RF_E/MEM_RF_E/WB_RF_E and load_instr signals that the hazard/forwarding unit compares against. Accepts that unit's CUMUX_E bubble request, plus a branch flush and a global hold. Keeps saturating retire and stall-bubble counters for performance debug.

---
 rtl/dest_reg_pipeline.sv | 91 +++++++++
 tb/tb_dest_reg_pipeline.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dest_reg_pipeline.sv
// Destination-register pipeline: carries {valid, rd, rf_e, load} for each
// issued instruction through EX, MEM and WB. The hazard/forwarding unit
// compares against these registered outputs. Also keeps saturating retire
// and stall-bubble counters for performance debug.
module dest_reg_pipeline #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_e,
    input  logic              id_load,
    input  logic              CUMUX_E,
    input  logic              flush_e,
    input  logic              hold_e,
    output logic [REG_AW-1:0] RD_EX,
    output logic [REG_AW-1:0] RD_MEM,
    output logic [REG_AW-1:0] RD_WB,
    output logic              EX_RF_E,
    output logic              MEM_RF_E,
    output logic              WB_RF_E,
    output logic              load_instr,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rf_e;
        logic              load;
    } entry_t;

    entry_t            ex_q, mem_q, wb_q;
    entry_t            new_entry;
    logic              wr_en;
    logic [CNT_W-1:0]  retire_q, bubble_q;

    // Build the entry entering EX; stalls, flushes and empty ID slots become bubbles.
    // rd=0 never raises rf_e/load so forwarding can never match on x0.
    always_comb begin
        new_entry = '0;
        wr_en     = id_rf_e & (id_rd != '0);
        if (id_valid && !CUMUX_E && !flush_e) begin
            new_entry.valid = 1'b1;
            new_entry.rd    = id_rd;
            new_entry.rf_e  = wr_en;
            new_entry.load  = id_load & wr_en;
        end
    end

    // Stage registers: shift EX->MEM->WB unless frozen by hold_e.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hold_e) begin
            ex_q  <= new_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating counters: retire when a valid entry leaves WB, count
    // CUMUX_E stalls that are not also flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else if (!hold_e) begin
            if (wb_q.valid && (retire_q != '1))
                retire_q <= retire_q + CNT_W'(1);
            if (CUMUX_E && !flush_e && (bubble_q != '1))
                bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign RD_EX        = ex_q.rd;
    assign RD_MEM       = mem_q.rd;
    assign RD_WB        = wb_q.rd;
    assign EX_RF_E      = ex_q.valid  & ex_q.rf_e;
    assign MEM_RF_E     = mem_q.valid & mem_q.rf_e;
    assign WB_RF_E      = wb_q.valid  & wb_q.rf_e;
    assign load_instr   = ex_q.load;
    assign retire_count = retire_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Bench for dest_reg_pipeline: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the three stages and the saturating counters.
module tb_dest_reg_pipeline;

    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rd;
    logic              id_rf_e, id_load, CUMUX_E, flush_e, hold_e;

    logic [REG_AW-1:0] rd_ex, rd_mem, rd_wb, s_rd_ex, s_rd_mem, s_rd_wb;
    logic              ex_we, mem_we, wb_we, ld, s_ex_we, s_mem_we, s_wb_we, s_ld;
    logic [31:0]       ret32, bub32;
    logic [3:0]        ret4, bub4;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    dest_reg_pipeline #(.REG_AW(REG_AW), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_rf_e(id_rf_e), .id_load(id_load), .CUMUX_E(CUMUX_E),
        .flush_e(flush_e), .hold_e(hold_e),
        .RD_EX(rd_ex), .RD_MEM(rd_mem), .RD_WB(rd_wb),
        .EX_RF_E(ex_we), .MEM_RF_E(mem_we), .WB_RF_E(wb_we),
        .load_instr(ld), .retire_count(ret32), .bubble_count(bub32)
    );

    dest_reg_pipeline #(.REG_AW(REG_AW), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_rf_e(id_rf_e), .id_load(id_load), .CUMUX_E(CUMUX_E),
        .flush_e(flush_e), .hold_e(hold_e),
        .RD_EX(s_rd_ex), .RD_MEM(s_rd_mem), .RD_WB(s_rd_wb),
        .EX_RF_E(s_ex_we), .MEM_RF_E(s_mem_we), .WB_RF_E(s_wb_we),
        .load_instr(s_ld), .retire_count(ret4), .bubble_count(bub4)
    );

    // Behavioural model: what each stage must present, index 0=EX 1=MEM 2=WB.
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ment_t;

    ment_t  m[3];
    longint m_ret32 = 0, m_bub32 = 0, m_ret4 = 0, m_bub4 = 0;

    function automatic longint sat_inc(longint v, longint lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    always @(posedge clk) begin
        ment_t n;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
            m_ret32 = 0; m_bub32 = 0; m_ret4 = 0; m_bub4 = 0;
        end else if (!hold_e) begin
            n = '{0, 0, 0, 0};
            if (id_valid && !CUMUX_E && !flush_e) begin
                n.v  = 1;
                n.rd = int'(id_rd);
                n.we = id_rf_e && (id_rd != 0);
                n.ld = n.we && id_load;
            end
            if (m[2].v) begin
                m_ret32 = sat_inc(m_ret32, 64'hFFFF_FFFF);
                m_ret4  = sat_inc(m_ret4, 15);
            end
            if (CUMUX_E && !flush_e) begin
                m_bub32 = sat_inc(m_bub32, 64'hFFFF_FFFF);
                m_bub4  = sat_inc(m_bub4, 15);
            end
            m[2] = m[1];
            m[1] = m[0];
            m[0] = n;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle after the first reset: both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("rd_ex",   longint'(rd_ex),  m[0].rd);
            chk("rd_mem",  longint'(rd_mem), m[1].rd);
            chk("rd_wb",   longint'(rd_wb),  m[2].rd);
            chk("ex_we",   longint'(ex_we),  longint'(m[0].we));
            chk("mem_we",  longint'(mem_we), longint'(m[1].we));
            chk("wb_we",   longint'(wb_we),  longint'(m[2].we));
            chk("load",    longint'(ld),     longint'(m[0].ld));
            chk("ret32",   longint'(ret32),  m_ret32);
            chk("bub32",   longint'(bub32),  m_bub32);
            chk("s_rd_ex", longint'(s_rd_ex), m[0].rd);
            chk("s_rd_wb", longint'(s_rd_wb), m[2].rd);
            chk("s_wb_we", longint'(s_wb_we), longint'(m[2].we));
            chk("s_mem_we", longint'(s_mem_we), longint'(m[1].we));
            chk("s_ex_we", longint'(s_ex_we) + 2 * longint'(s_ld) + 4 * longint'(s_rd_mem),
                longint'(m[0].we) + 2 * longint'(m[0].ld) + 4 * m[1].rd);
            chk("ret4",    longint'(ret4),   m_ret4);
            chk("bub4",    longint'(bub4),   m_bub4);
        end
    end

    task automatic drive(input bit v, input int rd, input bit rfe, input bit lo,
                         input bit cu, input bit fl, input bit ho);
        id_valid = v;
        id_rd    = REG_AW'(rd);
        id_rf_e  = rfe;
        id_load  = lo;
        CUMUX_E  = cu;
        flush_e  = fl;
        hold_e   = ho;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        started = 1;
        chk("reset_rd_ex", longint'(rd_ex), 0);
        chk("reset_ret", longint'(ret32), 0);
        rst_n = 1'b1;

        // 1: single writer flows EX -> MEM -> WB -> retire
        drive(1, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_rd_ex", longint'(rd_ex), 5);
        chk("t1_ex_we", longint'(ex_we), 1);
        idle(1);
        chk("t1_rd_mem", longint'(rd_mem), 5);
        chk("t1_mem_we", longint'(mem_we), 1);
        idle(1);
        chk("t1_rd_wb", longint'(rd_wb), 5);
        chk("t1_wb_we", longint'(wb_we), 1);
        idle(1);
        chk("t1_retire", longint'(ret32), 1);

        // 2: load, then a stall bubble behind it
        drive(1, 7, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("t2_load", longint'(ld), 1);
        chk("t2_rd_ex", longint'(rd_ex), 7);
        drive(1, 8, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("t2_bub_rd", longint'(rd_ex), 0);
        chk("t2_bub_we", longint'(ex_we), 0);
        chk("t2_bub_ld", longint'(ld), 0);
        chk("t2_mem_rd", longint'(rd_mem), 7);
        chk("t2_bubcnt", longint'(bub32), 1);

        // 3: x0 destination never writes but still retires
        drive(1, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("t3_we", longint'(ex_we), 0);
        chk("t3_ld", longint'(ld), 0);
        idle(1);
        chk("t3_mem_we", longint'(mem_we), 0);
        idle(5);
        chk("t3_retire", longint'(ret32), 3);

        // 4: fill rd=1,2,3 then hold with traffic and stall requests
        for (int i = 1; i <= 3; i++) begin
            drive(1, i, 1, 0, 0, 0, 0);
            @(negedge clk);
        end
        drive(1, 12, 1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_ex", longint'(rd_ex), 3);
            chk("t4_hold_mem", longint'(rd_mem), 2);
            chk("t4_hold_wb", longint'(rd_wb), 1);
            chk("t4_hold_ret", longint'(ret32), 3);
            chk("t4_hold_bub", longint'(bub32), 1);
        end
        idle(1);
        chk("t4_resume_wb", longint'(rd_wb), 2);
        chk("t4_resume_ret", longint'(ret32), 4);

        // 5: flush+stall together, then reset during a stall
        drive(1, 9, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk("t5_rd_ex", longint'(rd_ex), 0);
        chk("t5_bub", longint'(bub32), 1);
        drive(1, 9, 1, 0, 1, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_mem", longint'(rd_mem), 0);
        chk("t5_rst_ret", longint'(ret32), 0);
        chk("t5_rst_bub", longint'(bub32), 0);
        rst_n = 1'b1;

        // 6: 20 stalls saturate the 4-bit counter at 15
        drive(1, 4, 1, 0, 1, 0, 0);
        repeat (20) @(negedge clk);
        chk("t6_sat4", longint'(bub4), 15);
        chk("t6_bub32", longint'(bub32), 20);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
